// File: rtl/boot_mem_if.sv
// Core-facing bus and load-stream signals shared between boot_mem and its neighbours.
// The source of the image/address drives through master; boot_mem sits on slave.
interface boot_mem_if;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] address;
    logic [7:0]  rd_data;

    modport master (output s_data, s_valid, address, input s_ready, rd_data);
    modport slave  (input s_data, s_valid, address, output s_ready, rd_data);
endinterface

// File: rtl/boot_mem.sv
// Program RAM in front of the 6502: loads an image from a byte stream, patches the
// reset vector, then releases the core. Optional trailing checksum: BOOT_MEM_CHECKSUM_EN.
module boot_mem #(
    parameter int MEM_AW = 12
) (
    input  logic       clk,
    input  logic       resetn,
    boot_mem_if.slave  bus,
    output logic       cpu_resetn,
    output logic       busy,
    output logic       err
);
    localparam logic [15:0] VEC_LO_ADDR = 16'hFFFC;
    localparam logic [15:0] VEC_HI_ADDR = 16'hFFFD;

    typedef enum logic [3:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
`ifdef BOOT_MEM_CHECKSUM_EN
        S_CSUM,
`endif
        S_VEC_LO,
        S_VEC_HI,
        S_RELEASE,
        S_RUN,
        S_ERROR
    } state_t;

    state_t state, state_n;

    logic [7:0]        mem [2**MEM_AW];
    logic [1:0]        hcnt;
    logic [15:0]       la;
    logic [7:0]        len_lo;
    logic [15:0]       wa;
    logic [15:0]       remaining;
`ifdef BOOT_MEM_CHECKSUM_EN
    logic [7:0]        sum;
`endif

    logic              ready;
    logic              hs;
    logic              we;
    logic [MEM_AW-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              unused_addr_hi;

    assign bus.s_ready    = ready;
    assign hs             = bus.s_valid && ready;
    // Zero-cycle read: the core samples this the edge after it drives address.
    assign bus.rd_data    = mem[bus.address[MEM_AW-1:0]];
    assign unused_addr_hi = ^bus.address[15:MEM_AW];

`ifdef BOOT_MEM_CHECKSUM_EN
    assign err = (state == S_ERROR);
`else
    assign err = 1'b0;
`endif

    always_comb begin
        state_n = state;
        ready   = 1'b0;
        we      = 1'b0;
        wr_addr = wa[MEM_AW-1:0];
        wr_data = bus.s_data;
        case (state)
            S_IDLE: state_n = S_HDR;
            S_HDR: begin
                ready = 1'b1;
                if (hs && hcnt == 2'd3) begin
                    if ({bus.s_data, len_lo} != 16'd0)
                        state_n = S_DATA;
                    else
`ifdef BOOT_MEM_CHECKSUM_EN
                        state_n = S_CSUM;
`else
                        state_n = S_VEC_LO;
`endif
                end
            end
            S_DATA: begin
                ready = 1'b1;
                if (hs) begin
                    we = 1'b1;
                    if (remaining == 16'd1)
`ifdef BOOT_MEM_CHECKSUM_EN
                        state_n = S_CSUM;
`else
                        state_n = S_VEC_LO;
`endif
                end
            end
`ifdef BOOT_MEM_CHECKSUM_EN
            S_CSUM: begin
                ready = 1'b1;
                if (hs)
                    state_n = (bus.s_data == sum) ? S_VEC_LO : S_ERROR;
            end
`endif
            S_VEC_LO: begin
                we      = 1'b1;
                wr_addr = VEC_LO_ADDR[MEM_AW-1:0];
                wr_data = la[7:0];
                state_n = S_VEC_HI;
            end
            S_VEC_HI: begin
                we      = 1'b1;
                wr_addr = VEC_HI_ADDR[MEM_AW-1:0];
                wr_data = la[15:8];
                state_n = S_RELEASE;
            end
            S_RELEASE: state_n = S_RUN;
            S_RUN:     state_n = S_RUN;
            S_ERROR:   state_n = S_ERROR;
            default:   state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= S_IDLE;
            hcnt       <= 2'd0;
            la         <= 16'd0;
            len_lo     <= 8'd0;
            wa         <= 16'd0;
            remaining  <= 16'd0;
            cpu_resetn <= 1'b0;
            busy       <= 1'b0;
`ifdef BOOT_MEM_CHECKSUM_EN
            sum        <= 8'd0;
`endif
        end else begin
            state      <= state_n;
            cpu_resetn <= (state_n == S_RUN);
            busy       <= (state_n != S_RUN) && (state_n != S_ERROR);
            case (state)
                S_IDLE: begin
                    hcnt <= 2'd0;
`ifdef BOOT_MEM_CHECKSUM_EN
                    sum  <= 8'd0;
`endif
                end
                S_HDR: if (hs) begin
                    hcnt <= hcnt + 2'd1;
                    case (hcnt)
                        2'd0: la[7:0]  <= bus.s_data;
                        2'd1: la[15:8] <= bus.s_data;
                        2'd2: len_lo   <= bus.s_data;
                        default: begin
                            wa        <= la;
                            remaining <= {bus.s_data, len_lo};
                        end
                    endcase
                end
                S_DATA: if (hs) begin
                    wa        <= wa + 16'd1;
                    remaining <= remaining - 16'd1;
`ifdef BOOT_MEM_CHECKSUM_EN
                    sum       <= sum + bus.s_data;
`endif
                end
                default: ;
            endcase
        end
    end

    // RAM is deliberately not reset; a partial image survives an aborted load.
    always_ff @(posedge clk) begin
        if (we)
            mem[wr_addr] <= wr_data;
    end
endmodule

// File: tb/tb_boot_mem.sv
// Self-checking bench for boot_mem: directed and randomized image loads against an
// array model of the RAM built from stream contents.
module tb_boot_mem;
    localparam int AW    = 12;
    localparam int DEPTH = 1 << AW;

    typedef logic [7:0] byte_q_t[$];

    logic clk = 1'b0;
    logic resetn;
    logic cpu_resetn, busy, err;
    int   n_chk = 0;
    int   n_fail = 0;

    logic [7:0] mdl [DEPTH];
    bit         mv  [DEPTH];

    boot_mem_if bus ();

    boot_mem #(.MEM_AW(AW)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .bus        (bus.slave),
        .cpu_resetn (cpu_resetn),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn      = 1'b0;
        bus.s_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_s_ready", bus.s_ready, 1'b0);
        chk("rst_cpu_resetn", cpu_resetn, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err, 1'b0);
        resetn = 1'b1;
    endtask

    // Reference: payload lands at la+i modulo 64K, folded into the RAM mirror.
    task automatic model_load(input logic [15:0] la, input byte_q_t p, input bit vec);
        logic [15:0] a;
        for (int i = 0; i < p.size(); i++) begin
            a = la + 16'(i);
            mdl[a[AW-1:0]] = p[i];
            mv[a[AW-1:0]]  = 1'b1;
        end
        if (vec) begin
            mdl[DEPTH-4] = la[7:0];
            mdl[DEPTH-3] = la[15:8];
            mv[DEPTH-4]  = 1'b1;
            mv[DEPTH-3]  = 1'b1;
        end
    endtask

    function automatic byte_q_t build(input logic [15:0] la, input byte_q_t p, input bit bad);
        byte_q_t q;
        logic [7:0] s;
        logic [15:0] n;
        n = 16'(p.size());
        q = {la[7:0], la[15:8], n[7:0], n[15:8]};
        s = 8'd0;
        foreach (p[i]) begin
            q.push_back(p[i]);
            s = s + p[i];
        end
`ifdef BOOT_MEM_CHECKSUM_EN
        q.push_back(bad ? s - 8'd1 : s);
`else
        if (bad) q.push_back(s);
`endif
        return q;
    endfunction

    // gap_pct: chance of s_valid low per cycle; 200 means strictly alternating.
    task automatic send(input byte_q_t q, input int gap_pct);
        int i   = 0;
        int cyc = 0;
        int budget;
        bit hs;
        budget = 30 * q.size() + 100;
        while (i < q.size() && cyc < budget) begin
            @(negedge clk);
            cyc++;
            chk("load_cpu_resetn", cpu_resetn, 1'b0);
            chk("load_busy", busy, 1'b1);
            if (gap_pct == 200) bus.s_valid = cyc[0];
            else                bus.s_valid = ($urandom_range(99) >= gap_pct);
            bus.s_data = bus.s_valid ? q[i] : 8'($urandom);
            hs = bus.s_valid && bus.s_ready;
            @(posedge clk);
            if (hs) i++;
        end
        chk("stream_done", i, q.size());
    endtask

    // Junk on the stream after the last byte must be ignored while the vector is patched.
    task automatic expect_release();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.s_valid = 1'b1;
            bus.s_data  = 8'($urandom);
            chk("rel_cpu_resetn", cpu_resetn, (k == 3));
            chk("rel_s_ready", bus.s_ready, 1'b0);
        end
        chk("run_busy", busy, 1'b0);
        chk("run_err", err, 1'b0);
        @(negedge clk);
        bus.s_valid = 1'b0;
    endtask

    task automatic check_mem();
        for (int a = 0; a < DEPTH; a++) begin
            if (mv[a]) begin
                bus.address = {4'($urandom), 12'(a)};
                #1;
                chk($sformatf("rd_%03h", a), bus.rd_data, mdl[a]);
            end
        end
    endtask

    task automatic full_load(input logic [15:0] la, input byte_q_t p, input int gap_pct);
        do_reset();
        send(build(la, p, 1'b0), gap_pct);
        model_load(la, p, 1'b1);
        expect_release();
        check_mem();
    endtask

    initial begin
        byte_q_t p, q, part;
        logic [15:0] la;
        resetn      = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = 8'd0;
        bus.address = 16'd0;
        foreach (mv[i]) mv[i] = 1'b0;

        p = {8'hA9, 8'h55, 8'hEA};
        full_load(16'h0200, p, 0);
        bus.address = 16'h0200; #1; chk("fetch_opcode", bus.rd_data, 8'hA9);
        bus.address = 16'h0201; #1; chk("fetch_operand", bus.rd_data, 8'h55);
        bus.address = 16'hFFFD; #1; chk("vec_hi", bus.rd_data, 8'h02);

        p = {};
        full_load(16'h0400, p, 0);
        bus.address = 16'hFFFC; #1; chk("len0_vec_lo", bus.rd_data, 8'h00);
        bus.address = 16'hFFFD; #1; chk("len0_vec_hi", bus.rd_data, 8'h04);

        p = {8'hA9, 8'h55, 8'hEA};
        full_load(16'h0200, p, 200);

        p = {8'h11, 8'h22, 8'h33, 8'h44};
        full_load(16'hFFFE, p, 0);
        bus.address = 16'h0000; #1; chk("wrap_000", bus.rd_data, 8'h33);
        bus.address = 16'h1001; #1; chk("wrap_001", bus.rd_data, 8'h44);

        // Abort after two payload bytes, then reload the whole image.
        p  = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        q  = build(16'h0730, p, 1'b0);
        part = q[0:5];
        do_reset();
        send(part, 30);
        @(negedge clk);
        resetn = 1'b0;
        chk("abort_cpu_resetn", cpu_resetn, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("abort_cpu_resetn2", cpu_resetn, 1'b0);
        chk("abort_busy", busy, 1'b0);
        full_load(16'h0730, p, 30);

`ifdef BOOT_MEM_CHECKSUM_EN
        p = {8'hA9, 8'h55, 8'hEA};
        do_reset();
        send(build(16'h0300, p, 1'b1), 0);
        model_load(16'h0300, p, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.s_valid = 1'b1;
            bus.s_data  = 8'($urandom);
            chk("err_err", err, 1'b1);
            chk("err_cpu_resetn", cpu_resetn, 1'b0);
            chk("err_busy", busy, 1'b0);
            chk("err_s_ready", bus.s_ready, 1'b0);
        end
        bus.s_valid = 1'b0;
        check_mem();
`endif

        for (int t = 0; t < 6; t++) begin
            p = {};
            la = 16'($urandom);
            for (int i = 0; i < int'($urandom_range(64, 1)); i++)
                p.push_back(8'($urandom));
            full_load(la, p, int'($urandom_range(60)));
        end

        p = {};
        for (int i = 0; i < DEPTH + 4; i++) p.push_back(8'($urandom));
        full_load(16'($urandom), p, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
